// File: rtl/sync_pkg.sv
// Shared defaults and sizing helpers for the synchronous receive buffer.
// Imported by the buffer top and its storage sub-module.
package sync_pkg;

    localparam int DEFAULT_BUS_WIDTH        = 4;
    localparam int DEFAULT_DEPTH            = 4;
    localparam int DEFAULT_DROP_COUNT_WIDTH = 8;

    // Pointer width; a single entry still needs one address bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_rx_fifo_mem.sv
// DEPTH x BUS_WIDTH register array with a synchronous write port and a
// combinational read port, so the head word is visible without a read cycle.
module sync_rx_fifo_mem
    import sync_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PTR_W     = ptr_width(DEFAULT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [PTR_W-1:0]     waddr_i,
    input  logic [BUS_WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0]     raddr_i,
    output logic [BUS_WIDTH-1:0] rdata_o
);

    logic [BUS_WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_rx_buffer.sv
// FWFT receive buffer that captures one-cycle valid pulses from the
// synchronizer and hands them to a possibly-stalling consumer.
module sync_rx_buffer
    import sync_pkg::*;
#(
    parameter int BUS_WIDTH        = DEFAULT_BUS_WIDTH,
    parameter int DEPTH            = DEFAULT_DEPTH,
    parameter int DROP_COUNT_WIDTH = DEFAULT_DROP_COUNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        synchronous_data_valid,
    input  logic [BUS_WIDTH-1:0]        synchronous_data,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        full_q, full_d;
    logic                        empty_q, empty_d;
    logic                        overflow_q, overflow_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

    logic                        push, pop, at_full, accept, drop;
    logic [BUS_WIDTH-1:0]        rd_data;

    // Handshake: a word transfers on every cycle where out_valid && out_ready;
    // out_valid never depends on out_ready, and out_data holds while stalled.
    always_comb begin
        push         = synchronous_data_valid;
        pop          = !empty_q && out_ready;
        at_full      = (count_q == CNT_W'(DEPTH));
        accept       = push && (!at_full || pop);
        drop         = push && at_full && !pop;

        wr_ptr_d     = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d      = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d       = (count_d == CNT_W'(DEPTH));
        empty_d      = (count_d == '0);
        overflow_d   = overflow_q | drop;

        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    sync_rx_fifo_mem #(
        .BUS_WIDTH (BUS_WIDTH),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (accept && !reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (synchronous_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Masking keeps out_data at zero while empty, including straight after reset.
    assign out_data   = empty_q ? '0 : rd_data;
    assign out_valid  = !empty_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_sync_rx_buffer.sv
// Bench for sync_rx_buffer: directed vector table, then random traffic
// checked against a queue-based reference model.
module tb_sync_rx_buffer;

    localparam int BW    = 4;
    localparam int DEPTH = 4;
    localparam int DCW   = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           synchronous_data_valid = 1'b0;
    logic [BW-1:0]  synchronous_data = '0;
    logic           out_ready = 1'b0;
    logic           out_valid;
    logic [BW-1:0]  out_data;
    logic           full;
    logic           empty;
    logic [2:0]     count;
    logic           overflow;
    logic [DCW-1:0] drop_count;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: queue of stored words plus overflow state.
    logic [BW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;
    int            m_drops = 0;

    sync_rx_buffer #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .DROP_COUNT_WIDTH(DCW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .synchronous_data_valid (synchronous_data_valid),
        .synchronous_data       (synchronous_data),
        .out_ready              (out_ready),
        .out_valid              (out_valid),
        .out_data               (out_data),
        .full                   (full),
        .empty                  (empty),
        .count                  (count),
        .overflow               (overflow),
        .drop_count             (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          push;
        logic [BW-1:0] data;
        logic          rdy;
        int            e_cnt;
        logic          e_val;
        logic [BW-1:0] e_data;
        logic          e_ovf;
        int            e_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic p, input logic [BW-1:0] d, input logic rd,
                       input int c, input logic v, input logic [BW-1:0] ed,
                       input logic o, input int dr);
        vec_t t;
        t.rst = r; t.push = p; t.data = d; t.rdy = rd;
        t.e_cnt = c; t.e_val = v; t.e_data = ed; t.e_ovf = o; t.e_drop = dr;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, and land 1 time unit after the edge.
    task automatic step(input logic r, input logic p, input logic [BW-1:0] d, input logic rd);
        logic pp;
        reset = r;
        synchronous_data_valid = p;
        synchronous_data = d;
        out_ready = rd;
        if (r) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_drops = 0;
        end else begin
            pp = (exp_q.size() > 0) && rd;
            if (pp) void'(exp_q.pop_front());
            if (p) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops != 255) m_drops++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"},      32'(count),      32'(exp_q.size()));
        chk({tag, ".empty"},      32'(empty),      32'(exp_q.size() == 0));
        chk({tag, ".full"},       32'(full),       32'(exp_q.size() == DEPTH));
        chk({tag, ".out_valid"},  32'(out_valid),  32'(exp_q.size() != 0));
        chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
        chk({tag, ".drop_count"}, 32'(drop_count), 32'(m_drops));
        if (exp_q.size() != 0) chk({tag, ".out_data"}, 32'(out_data), 32'(exp_q[0]));
    endtask

    initial begin
        int next_code;
        int delivered;
        logic p, rd;
        logic [BW-1:0] d;

        // rst push data rdy | cnt val data ovf drops
        add(1, 0, 4'h0, 0,  0, 0, 4'h0, 0, 0);   // reset
        add(0, 1, 4'hA, 0,  1, 1, 4'hA, 0, 0);   // single push
        add(0, 0, 4'h0, 1,  0, 0, 4'h0, 0, 0);   // pop it
        add(0, 1, 4'h1, 0,  1, 1, 4'h1, 0, 0);   // fill 1..4
        add(0, 1, 4'h2, 0,  2, 1, 4'h1, 0, 0);
        add(0, 1, 4'h3, 0,  3, 1, 4'h1, 0, 0);
        add(0, 1, 4'h4, 0,  4, 1, 4'h1, 0, 0);
        add(0, 1, 4'h5, 0,  4, 1, 4'h1, 1, 1);   // dropped on full
        add(0, 0, 4'h0, 1,  3, 1, 4'h2, 1, 1);
        add(0, 0, 4'h0, 1,  2, 1, 4'h3, 1, 1);
        add(0, 0, 4'h0, 1,  1, 1, 4'h4, 1, 1);
        add(0, 0, 4'h0, 1,  0, 0, 4'h0, 1, 1);   // 5 never appears
        add(0, 1, 4'h7, 0,  1, 1, 4'h7, 1, 1);   // refill across pointer wrap
        add(0, 1, 4'h8, 0,  2, 1, 4'h7, 1, 1);
        add(0, 1, 4'h9, 0,  3, 1, 4'h7, 1, 1);
        add(0, 1, 4'hB, 0,  4, 1, 4'h7, 1, 1);
        add(0, 1, 4'h6, 1,  4, 1, 4'h8, 1, 1);   // push+pop at full: no drop
        add(0, 0, 4'h0, 1,  3, 1, 4'h9, 1, 1);
        add(0, 0, 4'h0, 1,  2, 1, 4'hB, 1, 1);
        add(0, 0, 4'h0, 1,  1, 1, 4'h6, 1, 1);
        add(0, 0, 4'h0, 1,  0, 0, 4'h0, 1, 1);
        add(0, 1, 4'h1, 0,  1, 1, 4'h1, 1, 1);
        add(0, 1, 4'h2, 0,  2, 1, 4'h1, 1, 1);
        add(0, 1, 4'h3, 0,  3, 1, 4'h1, 1, 1);
        add(1, 1, 4'hC, 1,  0, 0, 4'h0, 0, 0);   // reset with push and pop
        add(0, 0, 4'h0, 1,  0, 0, 4'h0, 0, 0);   // C was not stored

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].push, vecs[i].data, vecs[i].rdy);
            chk($sformatf("v%0d.count", i),      32'(count),      32'(vecs[i].e_cnt));
            chk($sformatf("v%0d.out_valid", i),  32'(out_valid),  32'(vecs[i].e_val));
            chk($sformatf("v%0d.empty", i),      32'(empty),      32'(vecs[i].e_cnt == 0));
            chk($sformatf("v%0d.full", i),       32'(full),       32'(vecs[i].e_cnt == DEPTH));
            chk($sformatf("v%0d.overflow", i),   32'(overflow),   32'(vecs[i].e_ovf));
            chk($sformatf("v%0d.drop_count", i), 32'(drop_count), 32'(vecs[i].e_drop));
            if (vecs[i].e_val || vecs[i].rst)
                chk($sformatf("v%0d.out_data", i), 32'(out_data), 32'(vecs[i].e_data));
        end

        // Codes 0..15 in order with random stalls, never overfilling.
        next_code = 0;
        delivered = 0;
        for (int cyc = 0; cyc < 400 && delivered < 16; cyc++) begin
            rd = ($urandom_range(0, 1) == 1);
            p  = (next_code < 16) && (exp_q.size() < DEPTH) && ($urandom_range(0, 2) != 0);
            if (out_valid && rd) begin
                chk("seq.order", 32'(out_data), 32'(delivered));
                delivered++;
            end
            step(0, p, BW'(next_code), rd);
            if (p) next_code++;
            check_model("seq");
        end
        chk("seq.delivered", 32'(delivered), 32'd16);
        chk("seq.overflow", 32'(overflow), 32'd0);

        // Unconstrained random traffic, drops included.
        for (int cyc = 0; cyc < 300; cyc++) begin
            p  = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 2) == 0);
            d  = BW'($urandom_range(0, 15));
            step(0, p, d, rd);
            check_model("rnd");
        end

        // Hold the consumer off long enough to saturate the drop counter.
        for (int cyc = 0; cyc < 270; cyc++) begin
            step(0, 1, BW'(cyc), 0);
            check_model("sat");
        end
        chk("sat.drop_count", 32'(drop_count), 32'd255);

        step(1, 0, '0, 0);
        check_model("rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
